// File: rtl/blink_pkg.sv
// Shared definitions for the blink-rate path: rate codes, debounce states and
// the half-period helper used to size and reload the divider.
package blink_pkg;

  localparam logic [1:0] RATE_1HZ = 2'b00;
  localparam logic [1:0] RATE_2HZ = 2'b01;
  localparam logic [1:0] RATE_4HZ = 2'b10;
  localparam logic [1:0] RATE_8HZ = 2'b11;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } deb_state_t;

  // Half-period in clock cycles for a rate code: clk_hz / (2 * 2^code), truncated.
  function automatic int unsigned hp_cycles(input logic [1:0] code,
                                            input int unsigned clk_hz);
    return clk_hz / (32'd2 << code);
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus debounce FSM for a W-bit switch code; a new code
// is accepted only after it has been seen unchanged for DEBOUNCE_CYC cycles.
module sw_debounce
  import blink_pkg::*;
#(
  parameter int          W            = 2,
  parameter int unsigned DEBOUNCE_CYC = 500_000
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_sw,
  output logic [W-1:0] o_code
);

  localparam int              CNT_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [W-1:0]     r_sync0;
  logic [W-1:0]     r_sync1;
  logic [W-1:0]     r_cand;
  logic [W-1:0]     r_code;
  logic [CNT_W-1:0] r_cnt;
  deb_state_t       r_state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync0 <= '0;
      r_sync1 <= '0;
      r_cand  <= '0;
      r_code  <= '0;
      r_cnt   <= '0;
      r_state <= ST_STABLE;
    end else begin
      r_sync0 <= i_sw;
      r_sync1 <= r_sync0;
      case (r_state)
        ST_STABLE: begin
          if (r_sync1 != r_code) begin
            r_cand  <= r_sync1;
            r_cnt   <= '0;
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          // Returning to the accepted code cancels the candidate outright.
          if (r_sync1 == r_code) begin
            r_state <= ST_STABLE;
          end else if (r_sync1 != r_cand) begin
            r_cand <= r_sync1;
            r_cnt  <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_code  <= r_cand;
            r_state <= ST_STABLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_STABLE;
      endcase
    end
  end

  assign o_code = r_code;

endmodule

// File: rtl/blink_rate_gen.sv
// Blink-enable generator: debounced 2-bit rate select feeding a half-period
// divider whose rate is only switched at a toggle edge, so no runt phase occurs.
module blink_rate_gen
  import blink_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned DEBOUNCE_CYC = 500_000
) (
  input  logic       CLOCK_50,
  input  logic       RST_N,
  input  logic [1:0] SW,
  output logic       BLINK,
  output logic       TICK,
  output logic [1:0] RATE,
  output logic       RATE_CHG
);

  localparam int unsigned HP_MAX = hp_cycles(RATE_1HZ, CLK_HZ);
  localparam int          HP_W   = (HP_MAX > 1) ? $clog2(HP_MAX) : 1;

  function automatic logic [HP_W-1:0] hp_reload(input logic [1:0] code);
    return HP_W'(hp_cycles(code, CLK_HZ) - 1);
  endfunction

  logic [1:0]      w_deb_code;
  logic [HP_W-1:0] r_hp_cnt;
  logic            r_blink;
  logic            r_tick;
  logic [1:0]      r_rate;
  logic            r_rate_chg;

  sw_debounce #(
    .W           (2),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_sw_debounce (
    .i_clk  (CLOCK_50),
    .i_rst_n(RST_N),
    .i_sw   (SW),
    .o_code (w_deb_code)
  );

  // The debounced code is sampled only at a toggle, completing the current phase at the old rate.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      r_hp_cnt   <= hp_reload(RATE_1HZ);
      r_blink    <= 1'b1;
      r_tick     <= 1'b0;
      r_rate     <= RATE_1HZ;
      r_rate_chg <= 1'b0;
    end else if (r_hp_cnt == '0) begin
      r_hp_cnt   <= hp_reload(w_deb_code);
      r_blink    <= ~r_blink;
      r_tick     <= 1'b1;
      r_rate     <= w_deb_code;
      r_rate_chg <= (w_deb_code != r_rate);
    end else begin
      r_hp_cnt   <= r_hp_cnt - HP_W'(1);
      r_tick     <= 1'b0;
      r_rate_chg <= 1'b0;
    end
  end

  assign BLINK    = r_blink;
  assign TICK     = r_tick;
  assign RATE     = r_rate;
  assign RATE_CHG = r_rate_chg;

endmodule

// File: tb/tb_blink_rate_gen.sv
// Directed bench for blink_rate_gen with CLK_HZ=16, DEBOUNCE_CYC=4 (HP = 8/4/2/1).
module tb_blink_rate_gen;

  logic       CLOCK_50 = 1'b0;
  logic       RST_N;
  logic [1:0] SW;
  logic       BLINK;
  logic       TICK;
  logic [1:0] RATE;
  logic       RATE_CHG;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_rchg   = 0;
  logic [3:0] r_seen   = '0;

  blink_rate_gen #(
    .CLK_HZ      (16),
    .DEBOUNCE_CYC(4)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RST_N   (RST_N),
    .SW      (SW),
    .BLINK   (BLINK),
    .TICK    (TICK),
    .RATE    (RATE),
    .RATE_CHG(RATE_CHG)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // One clock: advance past the rising edge and sample on the falling edge.
  task automatic step();
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    if (RATE_CHG) n_rchg++;
    r_seen[RATE] = 1'b1;
  endtask

  // Cycles until the next TICK, or -1 if none within max_cyc.
  task automatic wait_tick(input int max_cyc, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      step();
      if (TICK) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int c;
    RST_N = 1'b0;
    SW    = 2'b00;
    repeat (3) step();
    n_checks++; if (BLINK !== 1'b1) begin n_fail++; $display("FAIL rst_blink got=%b exp=1", BLINK); end
    n_checks++; if (RATE !== 2'b00) begin n_fail++; $display("FAIL rst_rate got=%b exp=00", RATE); end
    n_checks++; if (TICK !== 1'b0) begin n_fail++; $display("FAIL rst_tick got=%b exp=0", TICK); end
    n_checks++; if (RATE_CHG !== 1'b0) begin n_fail++; $display("FAIL rst_rchg got=%b exp=0", RATE_CHG); end
    RST_N = 1'b1;
    wait_tick(40, c);
    n_checks++; if (c != 8) begin n_fail++; $display("FAIL rst_first_tick got=%0d exp=8", c); end
    n_checks++; if (BLINK !== 1'b0) begin n_fail++; $display("FAIL rst_first_blink got=%b exp=0", BLINK); end
    wait_tick(40, c);
    n_checks++; if (c != 8) begin n_fail++; $display("FAIL rst_second_tick got=%0d exp=8", c); end
    n_checks++; if (BLINK !== 1'b1) begin n_fail++; $display("FAIL rst_second_blink got=%b exp=1", BLINK); end
  endtask

  task automatic test_clean_change();
    int c;
    SW = 2'b10;
    wait_tick(40, c);
    n_checks++; if (c != 8) begin n_fail++; $display("FAIL clean_tick got=%0d exp=8", c); end
    n_checks++; if (RATE !== 2'b10) begin n_fail++; $display("FAIL clean_rate got=%b exp=10", RATE); end
    n_checks++; if (RATE_CHG !== 1'b1) begin n_fail++; $display("FAIL clean_rchg got=%b exp=1", RATE_CHG); end
    wait_tick(40, c);
    n_checks++; if (c != 2) begin n_fail++; $display("FAIL clean_hp1 got=%0d exp=2", c); end
    n_checks++; if (RATE_CHG !== 1'b0) begin n_fail++; $display("FAIL clean_rchg_once got=%b exp=0", RATE_CHG); end
    wait_tick(40, c);
    n_checks++; if (c != 2) begin n_fail++; $display("FAIL clean_hp2 got=%0d exp=2", c); end
  endtask

  task automatic test_reset_mid();
    int c;
    for (int i = 0; i < 10 && BLINK !== 1'b0; i++) step();
    n_checks++; if (RATE !== 2'b10) begin n_fail++; $display("FAIL mid_pre_rate got=%b exp=10", RATE); end
    RST_N = 1'b0;
    SW    = 2'b00;
    #1;
    n_checks++; if (BLINK !== 1'b1) begin n_fail++; $display("FAIL mid_async_blink got=%b exp=1", BLINK); end
    n_checks++; if (RATE !== 2'b00) begin n_fail++; $display("FAIL mid_async_rate got=%b exp=00", RATE); end
    n_checks++; if (TICK !== 1'b0) begin n_fail++; $display("FAIL mid_async_tick got=%b exp=0", TICK); end
    repeat (2) step();
    RST_N = 1'b1;
    wait_tick(40, c);
    n_checks++; if (c != 8) begin n_fail++; $display("FAIL mid_first_tick got=%0d exp=8", c); end
  endtask

  task automatic test_bounce();
    int ticks = 0;
    n_rchg = 0;
    r_seen = '0;
    SW = 2'b11;
    for (int i = 1; i <= 32; i++) begin
      step();
      if (i == 3) SW = 2'b00;
      if (TICK) ticks++;
    end
    n_checks++; if (ticks != 4) begin n_fail++; $display("FAIL bounce_ticks got=%0d exp=4", ticks); end
    n_checks++; if (n_rchg != 0) begin n_fail++; $display("FAIL bounce_rchg got=%0d exp=0", n_rchg); end
    n_checks++; if (r_seen !== 4'b0001) begin n_fail++; $display("FAIL bounce_rates got=%b exp=0001", r_seen); end
  endtask

  task automatic test_restart();
    int c;
    r_seen = '0;
    SW = 2'b01;
    repeat (2) step();
    SW = 2'b11;
    wait_tick(40, c);
    n_checks++; if (c != 6) begin n_fail++; $display("FAIL restart_tick1 got=%0d exp=6", c); end
    n_checks++; if (RATE !== 2'b00) begin n_fail++; $display("FAIL restart_rate1 got=%b exp=00", RATE); end
    wait_tick(40, c);
    n_checks++; if (c != 8) begin n_fail++; $display("FAIL restart_tick2 got=%0d exp=8", c); end
    n_checks++; if (RATE !== 2'b11) begin n_fail++; $display("FAIL restart_rate2 got=%b exp=11", RATE); end
    n_checks++; if (RATE_CHG !== 1'b1) begin n_fail++; $display("FAIL restart_rchg got=%b exp=1", RATE_CHG); end
    n_checks++; if (r_seen[1] !== 1'b0) begin n_fail++; $display("FAIL restart_saw01 got=%b exp=0", r_seen[1]); end
  endtask

  task automatic test_max_rate();
    int   c;
    int   notick   = 0;
    int   notoggle = 0;
    logic prev;
    logic b;
    prev = BLINK;
    for (int i = 0; i < 6; i++) begin
      step();
      if (!TICK) notick++;
      if (BLINK == prev) notoggle++;
      prev = BLINK;
    end
    n_checks++; if (notick != 0) begin n_fail++; $display("FAIL max_tick_low got=%0d exp=0", notick); end
    n_checks++; if (notoggle != 0) begin n_fail++; $display("FAIL max_no_toggle got=%0d exp=0", notoggle); end
    n_rchg = 0;
    SW = 2'b00;
    repeat (7) step();
    n_checks++; if (RATE !== 2'b11) begin n_fail++; $display("FAIL max_rate_hold got=%b exp=11", RATE); end
    step();
    n_checks++; if (RATE !== 2'b00) begin n_fail++; $display("FAIL max_rate_back got=%b exp=00", RATE); end
    n_checks++; if (RATE_CHG !== 1'b1 || n_rchg != 1) begin n_fail++; $display("FAIL max_rchg got=%b/%0d exp=1/1", RATE_CHG, n_rchg); end
    b = BLINK;
    wait_tick(40, c);
    n_checks++; if (c != 8) begin n_fail++; $display("FAIL max_back_hp got=%0d exp=8", c); end
    n_checks++; if (BLINK !== ~b) begin n_fail++; $display("FAIL max_back_blink got=%b exp=%b", BLINK, ~b); end
  endtask

  task automatic test_settle_on_toggle();
    int c;
    step();
    SW = 2'b10;
    wait_tick(40, c);
    n_checks++; if (c != 7) begin n_fail++; $display("FAIL settle_tick1 got=%0d exp=7", c); end
    n_checks++; if (RATE !== 2'b00 || RATE_CHG !== 1'b0) begin n_fail++; $display("FAIL settle_old got=%b/%b exp=00/0", RATE, RATE_CHG); end
    wait_tick(40, c);
    n_checks++; if (c != 8) begin n_fail++; $display("FAIL settle_tick2 got=%0d exp=8", c); end
    n_checks++; if (RATE !== 2'b10 || RATE_CHG !== 1'b1) begin n_fail++; $display("FAIL settle_new got=%b/%b exp=10/1", RATE, RATE_CHG); end
  endtask

  initial begin
    test_reset();
    test_clean_change();
    test_reset_mid();
    test_bounce();
    test_restart();
    test_max_rate();
    test_settle_on_toggle();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
